imem_fetch_unit: RTL

IMEM_FETCH_UNIT -- requirements
Module: imem_fetch_unit

---
 rtl/imem_pkg.sv | 10 +
 rtl/imem_ram.sv | 24 ++
 rtl/imem_fetch_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory fetch unit.
package imem_pkg;
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_e;
    localparam int ERR_MISALIGN = 0;
    localparam int ERR_RANGE = 1;
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;
endpackage

// File: rtl/imem_ram.sv
// imem_ram: DEPTH x WIDTH storage with one synchronous write and one synchronous read port.
module imem_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Read data only moves on a read, so a stalled response survives later writes.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: instruction fetch with one-cycle responses and a streamed program-load mode.
module imem_fetch_unit
    import imem_pkg::*;
#(
    parameter int              DEPTH  = 256,
    parameter int              WIDTH  = 32,
    parameter int              ADDR_W = 32,
    parameter logic [WIDTH-1:0] NOP   = WIDTH'(NOP_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_valid,
    output logic                     fetch_ready,
    input  logic [ADDR_W-1:0]        fetch_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WIDTH-1:0]         resp_data,
    output logic [1:0]               resp_err,
    input  logic                     load_start,
    input  logic [$clog2(DEPTH)-1:0] load_base,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [WIDTH-1:0]         load_data,
    input  logic                     load_last,
    output logic                     busy,
    output logic                     load_ovf
);
    localparam int OFF = $clog2(WIDTH / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH * (WIDTH / 8));
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_e           state_q, state_d;
    logic             resp_valid_q, resp_valid_d;
    logic [1:0]       resp_err_q, resp_err_d;
    logic             use_ram_q, use_ram_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             load_ovf_q, load_ovf_d;
    logic [WIDTH-1:0] ram_rdata;
    logic [IDX_W-1:0] fetch_idx;
    logic             misaligned, out_of_range, fetch_acc, beat;

    assign fetch_idx    = fetch_addr[OFF +: IDX_W];
    assign misaligned   = |fetch_addr[OFF-1:0];
    assign out_of_range = {1'b0, fetch_addr} >= LIMIT;
    assign fetch_ready  = (state_q == ST_RUN) && !load_start && (!resp_valid_q || resp_ready);
    assign fetch_acc    = fetch_valid && fetch_ready;
    assign load_ready   = (state_q == ST_LOAD);
    assign busy         = (state_q == ST_LOAD);
    assign beat         = load_valid && load_ready;

    // Data comes from the RAM read register only for clean fetches; errors give NOP, reset gives 0.
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_data  = use_ram_q ? ram_rdata : (|resp_err_q ? NOP : '0);
    assign load_ovf   = load_ovf_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        load_ovf_d   = load_ovf_q;
        resp_valid_d = fetch_acc || (resp_valid_q && !resp_ready);
        resp_err_d   = resp_err_q;
        use_ram_d    = fetch_acc ? !(misaligned || out_of_range) : use_ram_q;
        if (fetch_acc) begin
            resp_err_d[ERR_MISALIGN] = misaligned;
            resp_err_d[ERR_RANGE]    = out_of_range;
        end
        if (state_q == ST_RUN && load_start) begin
            state_d    = ST_LOAD;
            ptr_d      = load_base;
            load_ovf_d = 1'b0;
        end else if (beat) begin
            ptr_d      = (ptr_q == LAST_IDX) ? '0 : ptr_q + IDX_W'(1);
            load_ovf_d = load_ovf_q || (ptr_q == LAST_IDX);
            state_d    = load_last ? ST_RUN : ST_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            resp_valid_q <= 1'b0;
            resp_err_q   <= '0;
            use_ram_q    <= 1'b0;
            ptr_q        <= '0;
            load_ovf_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            use_ram_q    <= use_ram_d;
            ptr_q        <= ptr_d;
            load_ovf_q   <= load_ovf_d;
        end
    end

    imem_ram #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (beat),
        .waddr(ptr_q),
        .wdata(load_data),
        .re   (fetch_acc && !out_of_range),
        .raddr(fetch_idx),
        .rdata(ram_rdata)
    );
endmodule
